memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  - MIPS pipeline MEM stage: consumes the EX/MEM register from the execution stage,
//    performs data-memory load/store, and drives the MEM/WB register.
//  - MEM/WB register is also the forwarding source read back by the execution stage.
//  - Holds the word-addressed data memory; detects bad accesses and records them in a sticky fault flag.
// PARAMETERS
//  - ADDR_W  8  log2 of data memory depth in 32-bit words (default 256 words = 1 KiB)
// PORTS
//  - clk       in   1   rising-edge clock, single clock domain
//  - rst_n     in   1   asynchronous, active-low reset
//  - EXMEMReg  in   75  [31:0] ALU result/address, [63:32] store data, [68:64] writeRegister,
//                       [69] zero, [70] overflow, [71] MemRead, [72] MemToReg, [73] MemWrite, [74] RegWrite
//  - MEMWBReg  out  71  [31:0] load data, [36:32] writeRegister, [37] RegWrite,
//                       [69:38] ALU result, [70] MemToReg (registered)
//  - memFault  out  1   sticky: set by any misaligned or out-of-range access
//  - faultCnt  out  8   count of faulting accesses; saturates at 255
// BEHAVIOUR
//  - Reset (async, rst_n=0): MEMWBReg=0, memFault=0, faultCnt=0 immediately.
//    Memory contents are not reset. Reset mid-stream discards the in-flight instruction.
//  - Latency: exactly 1 cycle. EXMEMReg at edge N appears in MEMWBReg after edge N+1.
//    No stall or handshake; one instruction is accepted every cycle.
//  - Address decode:
//    - word index = EXMEMReg[ADDR_W+1:2]
//    - misaligned if EXMEMReg[1:0]!=0
//    - out-of-range if EXMEMReg[31:ADDR_W+2]!=0 (address is treated as unsigned)
//    - access = MemRead|MemWrite; fault = access & (misaligned|out-of-range)
//  - Store (MemWrite=1, no fault): mem[index] <= EXMEMReg[63:32] at the posedge.
//  - Load (MemRead=1, no fault): MEMWBReg[31:0] <= mem[index] at the posedge.
//    Read is read-before-write.
//    A load in cycle N+1 to an address stored in cycle N returns the new data.
//  - No load, or faulting load: MEMWBReg[31:0] <= 0.
//  - MemRead=MemWrite=1 in one instruction: store is performed; load data returns the old word.
//  - Fault:
//    - store suppressed; RegWrite forced 0 in MEMWBReg
//    - memFault <= 1 (held until reset)
//    - faultCnt <= faultCnt+1, saturating at 8'hFF
//  - Pass-through fields, registered unchanged when no squash applies:
//    - EXMEMReg[31:0] -> MEMWBReg[69:38]
//    - [68:64] -> [36:32]
//    - [72] -> [70]
//    - [74] -> [37]
//  - writeRegister==0 with RegWrite=1 is passed through; the register file ignores $zero.
//  - Zero flag [69] is not consumed by this stage.
// CONFIGURATION
//  - OVF_SQUASH_EN defined: when EXMEMReg[70] (overflow)=1:
//    - store suppressed; RegWrite forced 0; MEMWBReg[31:0]=0
//    - not counted as a fault (memFault and faultCnt unchanged)
//  - OVF_SQUASH_EN undefined: overflow flag ignored; instruction completes normally.
// TESTING
//  - Reset: rst_n=0 mid-cycle -> MEMWBReg=0, memFault=0, faultCnt=0 without waiting for a clk edge.
//  - Store then load:
//    - cycle 1: sw, addr=0x40, data=0x1234_5678
//    - cycle 2: lw, addr=0x40, rd=17, RegWrite=1, MemToReg=1
//    - required: MEMWBReg[31:0]=0x12345678, [36:32]=17, [37]=1, [70]=1
//  - R-type pass-through: ALU=-15 (0xFFFFFFF1), rd=19, RegWrite=1, no access
//    -> MEMWBReg[69:38]=0xFFFFFFF1, [31:0]=0, [37]=1.
//  - Misaligned store at addr=0x42 with data=0xDEAD:
//    - mem[0x10] unchanged (a later lw 0x40 returns the prior value)
//    - memFault=1, faultCnt=1
//  - Out-of-range load: addr=0x400 with ADDR_W=8 -> MEMWBReg[31:0]=0, [37]=0, faultCnt increments.
//    Repeated 300 times -> faultCnt=255.
//  - Overflow: add with overflow=1, RegWrite=1
//    - OVF_SQUASH_EN defined: MEMWBReg[37]=0, faultCnt unchanged
//    - OVF_SQUASH_EN undefined: MEMWBReg[37]=1

Source files
------------

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: data-memory load/store, MEM/WB register and sticky fault tracking.
// Optional define OVF_SQUASH_EN squashes instructions whose ALU result overflowed.
module memory_access_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [74:0] EXMEMReg,
    output logic [70:0] MEMWBReg,
    output logic        memFault,
    output logic [7:0]  faultCnt
);

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] word_idx;
    logic              mem_read;
    logic              mem_write;
    logic              misaligned;
    logic              out_of_range;
    logic              squash;
    logic              fault;
    logic              do_load;
    logic              do_store;
    logic              unused_flags;

    assign word_idx     = EXMEMReg[ADDR_W+1:2];
    assign mem_read     = EXMEMReg[71];
    assign mem_write    = EXMEMReg[73];
    assign misaligned   = |EXMEMReg[1:0];
    assign out_of_range = |EXMEMReg[31:ADDR_W+2];

`ifdef OVF_SQUASH_EN
    assign squash = EXMEMReg[70];
`else
    assign squash = 1'b0;
`endif

    // The zero flag is never consumed here, and overflow only matters with squashing enabled.
    assign unused_flags = ^EXMEMReg[70:69];

    // A squashed instruction performs no access, so it can never count as a fault.
    assign fault    = (mem_read | mem_write) & ~squash & (misaligned | out_of_range);
    assign do_load  = mem_read & ~squash & ~fault;
    assign do_store = mem_write & ~squash & ~fault;

    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[word_idx] <= EXMEMReg[63:32];
        end
    end

    // The load samples the array before this edge's store lands, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEMWBReg <= '0;
            memFault <= 1'b0;
            faultCnt <= 8'd0;
        end else begin
            MEMWBReg <= {EXMEMReg[72],
                         EXMEMReg[31:0],
                         EXMEMReg[74] & ~fault & ~squash,
                         EXMEMReg[68:64],
                         do_load ? mem[word_idx] : 32'd0};
            if (fault) begin
                memFault <= 1'b1;
                if (faultCnt != 8'hFF) begin
                    faultCnt <= faultCnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage (honours OVF_SQUASH_EN when defined).
module tb_memory_access_stage;

    logic        clk;
    logic        rst_n;
    logic [74:0] EXMEMReg;
    logic [70:0] MEMWBReg;
    logic        memFault;
    logic [7:0]  faultCnt;

    int passed;
    int total;
    logic [31:0] exp40;

    memory_access_stage #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EXMEMReg (EXMEMReg),
        .MEMWBReg (MEMWBReg),
        .memFault (memFault),
        .faultCnt (faultCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction, clock it in, and return 1 time unit after the edge.
    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic reg_write,
                                 input logic mem_to_reg, input logic ovf, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] wreg);
        EXMEMReg = {reg_write, wr_en, mem_to_reg, rd_en, ovf, 1'b0, wreg, data, addr};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        EXMEMReg = '0;
        #12;
        total++;
        if (MEMWBReg !== 71'd0 || memFault !== 1'b0 || faultCnt !== 8'd0)
            $display("[TB] FAIL reset_state: MEMWBReg=%h memFault=%b faultCnt=%0d, required all 0",
                     MEMWBReg, memFault, faultCnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1234_5678, 5'd0);
        total++;
        if (MEMWBReg[31:0] !== 32'd0 || MEMWBReg[37] !== 1'b0)
            $display("[TB] FAIL store_wb: data=%h rw=%b, required 0/0", MEMWBReg[31:0], MEMWBReg[37]);
        else passed++;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd17);
        total++;
        if (MEMWBReg[31:0] !== 32'h1234_5678)
            $display("[TB] FAIL load_data: got %h, required 12345678", MEMWBReg[31:0]);
        else passed++;
        total++;
        if (MEMWBReg[36:32] !== 5'd17 || MEMWBReg[37] !== 1'b1 || MEMWBReg[70] !== 1'b1)
            $display("[TB] FAIL load_ctrl: wreg=%0d rw=%b m2r=%b, required 17/1/1",
                     MEMWBReg[36:32], MEMWBReg[37], MEMWBReg[70]);
        else passed++;
        total++;
        if (MEMWBReg[69:38] !== 32'h40 || memFault !== 1'b0)
            $display("[TB] FAIL load_alu: alu=%h fault=%b, required 40/0", MEMWBReg[69:38], memFault);
        else passed++;
    endtask

    task automatic test_rtype();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF1, 32'h5555_AAAA, 5'd19);
        total++;
        if (MEMWBReg[69:38] !== 32'hFFFF_FFF1 || MEMWBReg[31:0] !== 32'd0)
            $display("[TB] FAIL rtype_data: alu=%h data=%h, required fffffff1/0",
                     MEMWBReg[69:38], MEMWBReg[31:0]);
        else passed++;
        total++;
        if (MEMWBReg[37] !== 1'b1 || MEMWBReg[36:32] !== 5'd19 || MEMWBReg[70] !== 1'b0 || faultCnt !== 8'd0)
            $display("[TB] FAIL rtype_ctrl: rw=%b wreg=%0d m2r=%b cnt=%0d, required 1/19/0/0",
                     MEMWBReg[37], MEMWBReg[36:32], MEMWBReg[70], faultCnt);
        else passed++;
    endtask

    task automatic test_misaligned_store();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h42, 32'h0000_DEAD, 5'd4);
        total++;
        if (memFault !== 1'b1 || faultCnt !== 8'd1 || MEMWBReg[37] !== 1'b0)
            $display("[TB] FAIL misaligned_flag: fault=%b cnt=%0d rw=%b, required 1/1/0",
                     memFault, faultCnt, MEMWBReg[37]);
        else passed++;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
        total++;
        if (MEMWBReg[31:0] !== 32'h1234_5678 || faultCnt !== 8'd1 || memFault !== 1'b1)
            $display("[TB] FAIL misaligned_nostore: data=%h cnt=%0d fault=%b, required 12345678/1/1",
                     MEMWBReg[31:0], faultCnt, memFault);
        else passed++;
    endtask

    task automatic test_read_write_same();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0000_AAAA, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0000_BBBB, 5'd6);
        total++;
        if (MEMWBReg[31:0] !== 32'h0000_AAAA)
            $display("[TB] FAIL rw_same_old: got %h, required 0000aaaa", MEMWBReg[31:0]);
        else passed++;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd6);
        total++;
        if (MEMWBReg[31:0] !== 32'h0000_BBBB)
            $display("[TB] FAIL rw_same_new: got %h, required 0000bbbb", MEMWBReg[31:0]);
        else passed++;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3FC, 32'hCAFE_F00D, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 5'd7);
        total++;
        if (MEMWBReg[31:0] !== 32'hCAFE_F00D || faultCnt !== 8'd1)
            $display("[TB] FAIL top_word: data=%h cnt=%0d, required cafef00d/1", MEMWBReg[31:0], faultCnt);
        else passed++;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd8);
        total++;
        if (MEMWBReg[31:0] === 32'hCAFE_F00D)
            $display("[TB] FAIL word0_alias: got %h, required not cafef00d", MEMWBReg[31:0]);
        else passed++;
    endtask

    task automatic test_overflow();
        logic exp_rw;
`ifdef OVF_SQUASH_EN
        exp_rw = 1'b0;
        exp40  = 32'h1234_5678;
`else
        exp_rw = 1'b1;
        exp40  = 32'h0000_0099;
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7, 32'h0, 5'd9);
        total++;
        if (MEMWBReg[37] !== exp_rw || faultCnt !== 8'd1 || MEMWBReg[69:38] !== 32'h7)
            $display("[TB] FAIL overflow_add: rw=%b cnt=%0d alu=%h, required %b/1/7",
                     MEMWBReg[37], faultCnt, MEMWBReg[69:38], exp_rw);
        else passed++;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_0099, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd10);
        total++;
        if (MEMWBReg[31:0] !== exp40 || faultCnt !== 8'd1)
            $display("[TB] FAIL overflow_store: data=%h cnt=%0d, required %h/1",
                     MEMWBReg[31:0], faultCnt, exp40);
        else passed++;
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd3);
            if (i == 0) begin
                total++;
                if (MEMWBReg[31:0] !== 32'd0 || MEMWBReg[37] !== 1'b0 || faultCnt !== 8'd2)
                    $display("[TB] FAIL oor_first: data=%h rw=%b cnt=%0d, required 0/0/2",
                             MEMWBReg[31:0], MEMWBReg[37], faultCnt);
                else passed++;
            end
            if (i == 252) begin
                total++;
                if (faultCnt !== 8'd254)
                    $display("[TB] FAIL oor_254: cnt=%0d, required 254", faultCnt);
                else passed++;
            end
        end
        total++;
        if (faultCnt !== 8'd255 || memFault !== 1'b1)
            $display("[TB] FAIL oor_saturate: cnt=%0d fault=%b, required 255/1", faultCnt, memFault);
        else passed++;
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd17);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (MEMWBReg !== 71'd0 || memFault !== 1'b0 || faultCnt !== 8'd0)
            $display("[TB] FAIL async_reset: MEMWBReg=%h fault=%b cnt=%0d, required all 0",
                     MEMWBReg, memFault, faultCnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd17);
        total++;
        if (MEMWBReg[31:0] !== exp40 || faultCnt !== 8'd0 || memFault !== 1'b0)
            $display("[TB] FAIL mem_retained: data=%h cnt=%0d fault=%b, required %h/0/0",
                     MEMWBReg[31:0], faultCnt, memFault, exp40);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        exp40  = 32'h1234_5678;
        test_reset();
        test_store_load();
        test_rtype();
        test_misaligned_store();
        test_read_write_same();
        test_overflow();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
